// File: rtl/uart_pkg.sv
// Shared encodings and parity helper for the UART RX parity engine.
// The parity-type enum values match the cfg_par_typ register field.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCUM    = 2'b01,
        ST_WAIT_PAR = 2'b10
    } rx_state_e;

    // Expected parity bit, given the XOR of all data bits in the frame.
    function automatic logic par_expected(input logic acc, input par_typ_e typ);
        logic exp_bit;
        case (typ)
            PAR_EVEN:  exp_bit = acc;
            PAR_ODD:   exp_bit = ~acc;
            PAR_MARK:  exp_bit = 1'b1;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_parity_engine.sv
// Serial parity accumulator and checker for the UART receive path.
// Reports a per-frame result plus sticky and saturating error status.
module uart_rx_parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_par_en,
    input  logic [1:0]       cfg_par_typ,
    input  logic             frame_start,
    input  logic             data_bit_vld,
    input  logic             data_bit,
    input  logic             par_bit_vld,
    input  logic             par_bit,
    input  logic             frame_abort,
    input  logic             err_clr,
    output logic             chk_done,
    output logic             par_err,
    output logic             par_err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             proto_err
);

    localparam int BC_W = $clog2(DATA_W + 1);

    rx_state_e   state;
    logic        acc;
    logic [BC_W-1:0] bit_cnt;
    logic        par_en_q;
    par_typ_e    par_typ_q;

    logic        in_accum;
    logic        in_wait_par;
    logic        frame_ctl;
    logic        data_take;
    logic        par_take;
    logic        last_bit;
    logic        par_mismatch;
    logic        err_event;
    logic        proto_hit;

    assign in_accum    = (state == ST_ACCUM);
    assign in_wait_par = (state == ST_WAIT_PAR);

    // A start or abort in the same cycle pre-empts any data/parity strobe.
    assign frame_ctl = frame_start | frame_abort;

    assign data_take = in_accum & data_bit_vld & ~par_bit_vld & ~frame_ctl;
    assign par_take  = in_wait_par & par_bit_vld & ~data_bit_vld & ~frame_ctl;
    assign last_bit  = (bit_cnt == BC_W'(DATA_W - 1));

    assign par_mismatch = (par_bit != par_expected(acc, par_typ_q));
    assign err_event    = par_take & par_mismatch;

    assign proto_hit = (data_bit_vld & par_bit_vld)
                     | (data_bit_vld & ~in_accum)
                     | (par_bit_vld & ~in_wait_par);

    // Frame sequencing and registered per-frame result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            chk_done  <= 1'b0;
            par_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            chk_done  <= 1'b0;
            proto_err <= proto_hit;
            if (frame_start) begin
                state   <= ST_ACCUM;
                par_err <= 1'b0;
            end else if (frame_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_ACCUM: begin
                        if (data_take && last_bit) begin
                            if (par_en_q) begin
                                state <= ST_WAIT_PAR;
                            end else begin
                                state    <= ST_IDLE;
                                chk_done <= 1'b1;
                                par_err  <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_PAR: begin
                        if (par_take) begin
                            state    <= ST_IDLE;
                            chk_done <= 1'b1;
                            par_err  <= par_mismatch;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Serial parity accumulator and frame configuration snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= 1'b0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (frame_start) begin
            acc       <= 1'b0;
            bit_cnt   <= '0;
            par_en_q  <= cfg_par_en;
            par_typ_q <= par_typ_e'(cfg_par_typ);
        end else if (data_take) begin
            acc     <= acc ^ data_bit;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Status: a new error outranks a simultaneous clear, so the count restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_sticky <= 1'b0;
            err_cnt        <= '0;
        end else if (err_event) begin
            par_err_sticky <= 1'b1;
            if (err_clr) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (err_clr) begin
            par_err_sticky <= 1'b0;
            err_cnt        <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// Directed bench: instance A (8 data bits, 2-bit counter) and B (5 data bits)
// share all stimulus; each scenario checks only the instance it targets.
module tb_uart_rx_parity_engine;

    logic       clk;
    logic       rst;
    logic       cfg_par_en;
    logic [1:0] cfg_par_typ;
    logic       frame_start;
    logic       data_bit_vld;
    logic       data_bit;
    logic       par_bit_vld;
    logic       par_bit;
    logic       frame_abort;
    logic       err_clr;

    logic       done_a, perr_a, stk_a, proto_a;
    logic [1:0] cnt_a;
    logic       done_b, perr_b, stk_b, proto_b;
    logic [7:0] cnt_b;

    int total = 0;
    int bad   = 0;
    int pulses_a = 0;

    uart_rx_parity_engine #(.DATA_W(8), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
        .frame_start(frame_start), .data_bit_vld(data_bit_vld), .data_bit(data_bit),
        .par_bit_vld(par_bit_vld), .par_bit(par_bit), .frame_abort(frame_abort),
        .err_clr(err_clr), .chk_done(done_a), .par_err(perr_a),
        .par_err_sticky(stk_a), .err_cnt(cnt_a), .proto_err(proto_a)
    );

    uart_rx_parity_engine #(.DATA_W(5), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
        .frame_start(frame_start), .data_bit_vld(data_bit_vld), .data_bit(data_bit),
        .par_bit_vld(par_bit_vld), .par_bit(par_bit), .frame_abort(frame_abort),
        .err_clr(err_clr), .chk_done(done_b), .par_err(perr_b),
        .par_err_sticky(stk_b), .err_cnt(cnt_b), .proto_err(proto_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_a === 1'b1) pulses_a++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic en, input logic [1:0] typ);
        cfg_par_en = en; cfg_par_typ = typ; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [8:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            data_bit_vld = 1'b1; data_bit = val[i];
            tick();
        end
        data_bit_vld = 1'b0; data_bit = 1'b0;
    endtask

    task automatic send_par(input logic b);
        par_bit_vld = 1'b1; par_bit = b;
        tick();
        par_bit_vld = 1'b0; par_bit = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if ({done_a, perr_a, stk_a, cnt_a, proto_a} !== 6'b0) begin
            bad++; $display("FAIL reset_a got=%b want=000000", {done_a, perr_a, stk_a, cnt_a, proto_a});
        end
        total++;
        if ({done_b, perr_b, stk_b, cnt_b, proto_b} !== 12'b0) begin
            bad++; $display("FAIL reset_b got=%b want=0", {done_b, perr_b, stk_b, cnt_b, proto_b});
        end
        rst = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_even_ok();
        start(1'b1, 2'b00);
        send_bits(9'h0A5, 8);
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL even_ok_early_done got=%b want=0", done_a); end
        send_par(1'b0);
        total++;
        if (done_a !== 1'b1) begin bad++; $display("FAIL even_ok_done got=%b want=1", done_a); end
        total++;
        if (perr_a !== 1'b0) begin bad++; $display("FAIL even_ok_perr got=%b want=0", perr_a); end
        total++;
        if (cnt_a !== 2'd0) begin bad++; $display("FAIL even_ok_cnt got=%0d want=0", cnt_a); end
        total++;
        if (proto_a !== 1'b0) begin bad++; $display("FAIL even_ok_proto got=%b want=0", proto_a); end
        tick();
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL even_ok_pulse got=%b want=0", done_a); end
        $display("even 0xA5 par=0: done=%b perr=%b cnt=%0d", done_a, perr_a, cnt_a);
    endtask

    task automatic test_even_err();
        start(1'b1, 2'b00);
        send_bits(9'h0A5, 8);
        send_par(1'b1);
        total++;
        if ({done_a, perr_a, stk_a, cnt_a} !== 5'b11101) begin
            bad++; $display("FAIL even_err got=%b want=11101", {done_a, perr_a, stk_a, cnt_a});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if ({perr_a, stk_a, cnt_a} !== 4'b1000) begin
            bad++; $display("FAIL err_clr got=%b want=1000", {perr_a, stk_a, cnt_a});
        end
        $display("even 0xA5 par=1 then clr: perr=%b sticky=%b cnt=%0d", perr_a, stk_a, cnt_a);
    endtask

    task automatic test_types();
        start(1'b1, 2'b01);
        send_bits(9'h007, 8);
        send_par(1'b0);
        total++;
        if ({done_a, perr_a} !== 2'b10) begin bad++; $display("FAIL odd got=%b want=10", {done_a, perr_a}); end
        $display("odd 0x07 par=0: done=%b perr=%b", done_a, perr_a);

        start(1'b1, 2'b10);
        send_bits(9'h007, 8);
        send_par(1'b0);
        total++;
        if ({done_a, perr_a, cnt_a} !== 4'b1101) begin bad++; $display("FAIL mark got=%b want=1101", {done_a, perr_a, cnt_a}); end
        $display("mark 0x07 par=0: done=%b perr=%b", done_a, perr_a);

        start(1'b1, 2'b11);
        total++;
        if (perr_a !== 1'b0) begin bad++; $display("FAIL start_clears_perr got=%b want=0", perr_a); end
        send_bits(9'h007, 8);
        send_par(1'b0);
        total++;
        if ({done_a, perr_a} !== 2'b10) begin bad++; $display("FAIL space got=%b want=10", {done_a, perr_a}); end
        $display("space 0x07 par=0: done=%b perr=%b", done_a, perr_a);

        start(1'b0, 2'b00);
        cfg_par_en = 1'b1;
        send_bits(9'h0A5, 7);
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL nopar_early got=%b want=0", done_a); end
        send_bits(9'h001, 1);
        total++;
        if ({done_a, perr_a} !== 2'b10) begin bad++; $display("FAIL nopar got=%b want=10", {done_a, perr_a}); end
        $display("parity off: done=%b perr=%b", done_a, perr_a);
        cfg_par_en = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] want_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (cnt_a !== 2'd0) begin bad++; $display("FAIL sat_clr got=%0d want=0", cnt_a); end
        for (int f = 0; f < 5; f++) begin
            start(1'b1, 2'b00);
            send_bits(9'h0A5, 8);
            send_par(1'b1);
            total++;
            if (cnt_a !== want_seq[f]) begin
                bad++; $display("FAIL sat_frame%0d got=%0d want=%0d", f, cnt_a, want_seq[f]);
            end
            $display("sat frame %0d: cnt=%0d", f, cnt_a);
        end
        start(1'b1, 2'b00);
        send_bits(9'h0A5, 8);
        err_clr = 1'b1;
        send_par(1'b1);
        err_clr = 1'b0;
        total++;
        if ({stk_a, cnt_a} !== 3'b101) begin bad++; $display("FAIL err_vs_clr got=%b want=101", {stk_a, cnt_a}); end
        $display("error with clr: sticky=%b cnt=%0d", stk_a, cnt_a);
    endtask

    task automatic test_abort();
        int p0;
        start(1'b1, 2'b00);
        send_bits(9'h00F, 4);
        p0 = pulses_a;
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        send_bits(9'h001, 1);
        total++;
        if (proto_a !== 1'b1) begin bad++; $display("FAIL idle_data_proto got=%b want=1", proto_a); end
        tick(); tick();
        total++;
        if (pulses_a - p0 !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", pulses_a - p0); end
        $display("abort after 4 bits: done pulses=%0d", pulses_a - p0);

        p0 = pulses_a;
        start(1'b1, 2'b01);
        send_bits(9'h005, 3);
        start(1'b1, 2'b00);
        send_bits(9'h0FF, 8);
        send_par(1'b0);
        total++;
        if (perr_a !== 1'b0) begin bad++; $display("FAIL restart_perr got=%b want=0", perr_a); end
        tick(); tick();
        total++;
        if (pulses_a - p0 !== 1) begin bad++; $display("FAIL restart_done got=%0d want=1", pulses_a - p0); end
        $display("restart 0xFF even: pulses=%0d perr=%b", pulses_a - p0, perr_a);
    endtask

    task automatic test_w5();
        start(1'b1, 2'b00);
        send_bits(9'h005, 3);
        send_par(1'b1);
        total++;
        if ({proto_b, done_b} !== 2'b10) begin bad++; $display("FAIL w5_proto got=%b want=10", {proto_b, done_b}); end
        send_bits(9'h001, 2);
        send_par(1'b1);
        total++;
        if ({done_b, perr_b} !== 2'b10) begin bad++; $display("FAIL w5_ok got=%b want=10", {done_b, perr_b}); end
        $display("w5 10110 even par=1: done=%b perr=%b", done_b, perr_b);

        start(1'b1, 2'b00);
        send_bits(9'h00D, 5);
        send_par(1'b0);
        total++;
        if ({done_b, perr_b, stk_b} !== 3'b111) begin bad++; $display("FAIL w5_err got=%b want=111", {done_b, perr_b, stk_b}); end

        start(1'b1, 2'b00);
        send_bits(9'h00D, 5);
        rst = 1'b0;
        #2;
        total++;
        if ({done_b, perr_b, stk_b, cnt_b, proto_b} !== 12'b0) begin
            bad++; $display("FAIL async_rst_b got=%b want=0", {done_b, perr_b, stk_b, cnt_b, proto_b});
        end
        total++;
        if ({done_a, perr_a, stk_a, cnt_a, proto_a} !== 6'b0) begin
            bad++; $display("FAIL async_rst_a got=%b want=0", {done_a, perr_a, stk_a, cnt_a, proto_a});
        end
        $display("async reset in WAIT_PAR: sticky_b=%b cnt_b=%0d", stk_b, cnt_b);
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 2'b00; frame_start = 1'b0;
        data_bit_vld = 1'b0; data_bit = 1'b0; par_bit_vld = 1'b0; par_bit = 1'b0;
        frame_abort = 1'b0; err_clr = 1'b0;
        test_reset();
        test_even_ok();
        test_even_err();
        test_types();
        test_saturation();
        test_abort();
        test_w5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
